video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 37 +++
 rtl/video_timing_gen_if.sv | 27 ++
 rtl/video_timing_gen_axis_counter.sv | 55 +++++
 rtl/video_timing_gen.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants for the video timing generator.
// - Default 640x480@60 timing constants and the per-axis total derivation.
// - Counter and colour component widths.
// - Colour bar table used by the optional test pattern.
package video_timing_pkg;

  localparam int unsigned CntW = 12;
  localparam int unsigned ColW = 8;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DefHTotal = axis_total(DefHActive, DefHFp, DefHSync, DefHBp);
  localparam int unsigned DefVTotal = axis_total(DefVActive, DefVFp, DefVSync, DefVBp);

  localparam int unsigned NumBars = 8;

  // {r, g, b} component enables; element 0 is the leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [NumBars-1:0][2:0] BarRgb = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing output bundle.
// master: the timing generator (drives timing/pixel outputs, receives en).
// slave : the consumer (TMDS encoder side; drives en, receives the rest).
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic            en;           // count enable
  logic            disp_en;      // active video
  logic [1:0]      ctrl;         // {vsync, hsync} at configured polarity
  logic [CntW-1:0] x;            // current column
  logic [CntW-1:0] y;            // current line
  logic            frame_start;  // one-clock pulse at x=0, y=0
  logic [ColW-1:0] red;
  logic [ColW-1:0] green;
  logic [ColW-1:0] blue;

  modport master (
    input  en,
    output disp_en, ctrl, x, y, frame_start, red, green, blue
  );

  modport slave (
    output en,
    input  disp_en, ctrl, x, y, frame_start, red, green, blue
  );

endinterface

// File: rtl/video_timing_gen_axis_counter.sv
// One axis (horizontal or vertical) of the timing generator.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   step_i        : advance the counter by one this clock
//   cnt_o         : current count, 0..Total-1
//   wrap_o        : count is at its maximum (next step wraps to 0)
//   active_o      : count lies in the active region
//   sync_o        : count lies in the sync pulse region (polarity-free)
module vtg_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned Active = DefHActive,
  parameter int unsigned Fp     = DefHFp,
  parameter int unsigned Sync   = DefHSync,
  parameter int unsigned Bp     = DefHBp
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            step_i,
  output logic [CntW-1:0] cnt_o,
  output logic            wrap_o,
  output logic            active_o,
  output logic            sync_o
);

  localparam int unsigned     Total     = axis_total(Active, Fp, Sync, Bp);
  localparam logic [CntW-1:0] CntMax    = CntW'(Total - 1);
  localparam logic [CntW-1:0] ActiveEnd = CntW'(Active);
  localparam logic [CntW-1:0] SyncStart = CntW'(Active + Fp);
  localparam logic [CntW-1:0] SyncEnd   = CntW'(Active + Fp + Sync);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign active_o = (cnt_q < ActiveEnd);
  assign sync_o   = (cnt_q >= SyncStart) && (cnt_q < SyncEnd);

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: raster counters plus registered sync/active decode.
// Ports:
//   clk_i  : pixel clock, all logic on the rising edge
//   rst_ni : asynchronous active-low reset
//   vid_io : video_timing_gen_if.master (en in; disp_en, ctrl, x, y,
//            frame_start, red/green/blue out)
// Every output is a register loaded from the decode of the current counter
// value, so all outputs lag the counters by one clock and stay aligned.
// en low freezes counters and every output register.
// Optional feature: define VTG_TEST_PATTERN_EN for 8 vertical colour bars on
// red/green/blue; otherwise they are tied to 0.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  video_timing_gen_if.master vid_io
);

  localparam logic       SyncAct  = (SYNC_POL != 0);
  localparam logic [1:0] CtrlIdle = {2{~SyncAct}};

  logic [CntW-1:0] h_cnt, v_cnt;
  logic            h_wrap, h_active, h_sync;
  logic            v_active, v_sync, v_wrap_unused;
  logic            v_step;

  // Lines advance only on the enabled clock that wraps the column counter.
  assign v_step = vid_io.en & h_wrap;

  vtg_axis_counter #(
    .Active (H_ACTIVE),
    .Fp     (H_FP),
    .Sync   (H_SYNC),
    .Bp     (H_BP)
  ) u_h_axis (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .step_i   (vid_io.en),
    .cnt_o    (h_cnt),
    .wrap_o   (h_wrap),
    .active_o (h_active),
    .sync_o   (h_sync)
  );

  vtg_axis_counter #(
    .Active (V_ACTIVE),
    .Fp     (V_FP),
    .Sync   (V_SYNC),
    .Bp     (V_BP)
  ) u_v_axis (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .step_i   (v_step),
    .cnt_o    (v_cnt),
    .wrap_o   (v_wrap_unused),
    .active_o (v_active),
    .sync_o   (v_sync)
  );

  logic            disp_en_q, disp_en_d;
  logic            frame_start_q, frame_start_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [CntW-1:0] x_q, x_d, y_q, y_d;

  always_comb begin
    disp_en_d     = disp_en_q;
    frame_start_d = frame_start_q;
    ctrl_d        = ctrl_q;
    x_d           = x_q;
    y_d           = y_q;
    if (vid_io.en) begin
      disp_en_d     = h_active & v_active;
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      // XOR with the idle level maps "in sync region" onto the active level.
      ctrl_d        = {v_sync, h_sync} ^ CtrlIdle;
      x_d           = h_cnt;
      y_d           = v_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_en_q     <= 1'b0;
      frame_start_q <= 1'b0;
      ctrl_q        <= CtrlIdle;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      disp_en_q     <= disp_en_d;
      frame_start_q <= frame_start_d;
      ctrl_q        <= ctrl_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign vid_io.disp_en     = disp_en_q;
  assign vid_io.frame_start = frame_start_q;
  assign vid_io.ctrl        = ctrl_q;
  assign vid_io.x           = x_q;
  assign vid_io.y           = y_q;

`ifdef VTG_TEST_PATTERN_EN
  localparam int unsigned BarW = H_ACTIVE / NumBars;

  logic [2:0] bar_idx;
  logic [2:0] rgb_q, rgb_d;

  // Bar index = number of bar boundaries at or left of the column; avoids a
  // divider by comparing against constant thresholds.
  always_comb begin
    bar_idx = '0;
    for (int unsigned k = 1; k < NumBars; k++) begin
      if (h_cnt >= CntW'(k * BarW)) begin
        bar_idx = 3'(k);
      end
    end
  end

  always_comb begin
    rgb_d = rgb_q;
    if (vid_io.en) begin
      rgb_d = (h_active & v_active) ? BarRgb[bar_idx] : 3'b000;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vid_io.red   = {ColW{rgb_q[2]}};
  assign vid_io.green = {ColW{rgb_q[1]}};
  assign vid_io.blue  = {ColW{rgb_q[0]}};
`else
  assign vid_io.red   = '0;
  assign vid_io.green = '0;
  assign vid_io.blue  = '0;
`endif

endmodule
